pipe_divider: RTL
=================

# pipe_divider

Multi-cycle iterative 32-bit divider for the dynamic pipeline CPU, executing DIV and DIVU. It sits directly upstream of the write-back stage, and its registered quotient `q` and remainder `r` drive that stage's `q`/`r` inputs. In write-back, `lo` takes `q` and `hi` takes `r`. The pipeline starts an operation with a one-cycle `start` pulse, stalls on `busy`, and consumes the result on the one-cycle `done` pulse.

## Interface
- Parameters: none (width fixed at 32).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sign`  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with `start`.
- `a`  in  32  dividend; sampled with `start`.
- `b`  in  32  divisor; sampled with `start`.
- `cancel`  in  1  pipeline flush/exception; aborts the operation in progress.
- `busy`  out  1  high while an operation is iterating (state RUN).
- `done`  out  1  one-cycle pulse; `q`/`r` are valid and final.
- `dz`  out  1  divide-by-zero flag for the last completed operation; valid with `done` and held afterwards.
- `q`  out  32  quotient, registered, held until the next completion.
- `r`  out  32  remainder, registered, held until the next completion.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, lasts exactly one cycle.
- Transitions, priority reset > cancel > start:
  - IDLE or DONE + `start` -> RUN. Latches the operand magnitudes, the sign of `a`, sign(`a`) XOR sign(`b`), `sign`, b==0, and clears the iteration count to 0.
  - DONE without `start` -> IDLE.
  - RUN, count == 31 -> DONE. `q`, `r` and `dz` are written on this same edge.
  - RUN + `cancel` -> IDLE. `q`, `r` and `dz` are unchanged and no `done` is produced.
- `start` while in RUN is ignored. Operands need not be held after the start cycle.
- Operand magnitudes:
  - Unsigned: operands are used as-is.
  - Signed: negative operands are two's-complement negated. 0x80000000 stays 0x80000000 and is treated as unsigned 2^31.
- Iteration: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder: `rem = {rem[31:0], dividend_msb}`.
  - If `rem >= divisor`: subtract, quotient bit = 1; otherwise quotient bit = 0.
- Sign correction, applied on the DONE-entry edge:
  - Signed only: negate `q` if sign(`a`) XOR sign(`b`); negate `r` if `a` was negative. The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `q` = 0x80000000, `r` = 0, with no flag.
- Divide by zero (`b` == 0):
  - Runs the full 32 cycles.
  - Forces `q` = 0xFFFFFFFF and `r` = `a` (original value) for both signed and unsigned; sign correction is bypassed.
  - Sets `dz` = 1. Any other completion clears `dz` to 0.
- Reset: state IDLE; `busy`=0, `done`=0, `dz`=0, `q`=0, `r`=0, count=0.

## Timing
- E0 is the edge sampling `start`=1.
  - `busy` is high in the cycles after E0 through E31, which is 32 cycles.
  - Iterations run on edges E1..E32. The last one, on E32, transitions to DONE and registers the results.
  - `done`=1 with valid `q`/`r`/`dz` in the cycle after E32 (33 cycles after `start`).
- Back-to-back operation: `start` in the DONE cycle puts the block in RUN on the next edge, so `busy` rises the cycle after `done` with no idle gap.
- `cancel` on any RUN cycle: `busy` is low the cycle after.
- `cancel` and `start` in the same cycle in IDLE/DONE: `cancel` wins and the block goes to IDLE. If that cycle is the DONE cycle, `done` is still high in it, because the results were already registered at E32.
- Reset mid-RUN: IDLE on the next edge and `q`/`r` cleared to 0.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Test plan
- Unsigned: `a`=7, `b`=2, `sign`=0 -> `done` 33 cycles after `start`, `q`=3, `r`=1, `dz`=0; `busy` high exactly 32 cycles.
- Signed: `a`=0xFFFFFFF9 (-7), `b`=2 -> `q`=0xFFFFFFFD, `r`=0xFFFFFFFF. Then `a`=7, `b`=0xFFFFFFFE -> `q`=0xFFFFFFFD, `r`=1.
- Signed overflow and large unsigned:
  - `a`=0x80000000, `b`=0xFFFFFFFF, `sign`=1 -> `q`=0x80000000, `r`=0.
  - Same operands with `sign`=0 -> `q`=0, `r`=0x80000000.
- Divide by zero: `a`=0x12345678, `b`=0, `sign`=1 -> after 33 cycles `q`=0xFFFFFFFF, `r`=0x12345678, `dz`=1. The next normal op clears `dz`.
- Cancel/ignore:
  - Complete 7/2, then start 100/7 and assert `cancel` on RUN cycle 10 -> `busy` low next cycle, no `done`, `q`=3, `r`=1 retained.
  - A `start` pulsed during RUN is ignored: exactly one `done` is produced.
- Back-to-back and reset:
  - `start` 100/7 asserted in the DONE cycle of the previous op -> `q`=14, `r`=2 after 33 more cycles.
  - `reset` mid-RUN -> next cycle `busy`=0, `done`=0, `q`=`r`=0.

Source files
------------

// File: rtl/pipe_divider.sv
// Iterative 32-bit restoring divider (DIV/DIVU) feeding the write-back stage.
// One quotient bit per cycle; results, busy and done are all registered.
module pipe_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic            load, step, finish;

  logic [CW-1:0]   count;
  logic [W-1:0]    dvd, dvs, rem, a_orig;
  logic            sgn, neg_q, neg_r, zero;

  logic [W:0]      rem_sh;
  logic            qbit;
  logic [W-1:0]    rem_next, dvd_next, q_fin, r_fin, a_mag, b_mag;

  // Next-state decode; cancel beats start, and a start during RUN is ignored.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (count == CW'(W - 1)) begin
            state_next = DONE;
            finish     = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (start && !cancel) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // One restoring step; the final step's result is also used for q/r directly.
  always_comb begin
    rem_sh   = {rem, dvd[W-1]};
    qbit     = (rem_sh >= {1'b0, dvs});
    rem_next = qbit ? (rem_sh[W-1:0] - dvs) : rem_sh[W-1:0];
    dvd_next = {dvd[W-2:0], qbit};
    a_mag    = (sign && a[W-1]) ? (W'(0) - a) : a;
    b_mag    = (sign && b[W-1]) ? (W'(0) - b) : b;
    q_fin    = dvd_next;
    r_fin    = rem_next;
    if (zero) begin
      q_fin = '1;
      r_fin = a_orig;
    end else if (sgn) begin
      if (neg_q) q_fin = W'(0) - dvd_next;
      if (neg_r) r_fin = W'(0) - rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      a_orig <= '0;
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero   <= 1'b0;
      q      <= '0;
      r      <= '0;
      dz     <= 1'b0;
    end else if (load) begin
      count  <= '0;
      dvd    <= a_mag;
      dvs    <= b_mag;
      rem    <= '0;
      a_orig <= a;
      sgn    <= sign;
      neg_q  <= a[W-1] ^ b[W-1];
      neg_r  <= a[W-1];
      zero   <= (b == '0);
    end else if (step) begin
      count <= count + CW'(1);
      dvd   <= dvd_next;
      rem   <= rem_next;
      if (finish) begin
        q  <= q_fin;
        r  <= r_fin;
        dz <= zero;
      end
    end
  end

endmodule
